// File: rtl/cardinal_pkg.sv
// Cardinal pipeline shared definitions.
// Purpose: issue-class codes, default per-class latencies, the opcode and
// function-code map of the Cardinal vector ISA, and the decode helper that
// ID uses to turn (opcode, funct) into the 3-bit issue class consumed by
// cardinal_scoreboard.
// Ports: none (package).
package cardinal_pkg;

  typedef enum logic [2:0] {
    CLS_LOGIC = 3'd0,
    CLS_MEM   = 3'd1,
    CLS_ADD   = 3'd2,
    CLS_SHIFT = 3'd3,
    CLS_MUL   = 3'd4,
    CLS_DIV   = 3'd5,
    CLS_NONE  = 3'd6
  } IssueClass;

  localparam int DEFAULT_LAT_LOGIC = 1;
  localparam int DEFAULT_LAT_MEM   = 2;
  localparam int DEFAULT_LAT_ADD   = 3;
  localparam int DEFAULT_LAT_SHIFT = 3;
  localparam int DEFAULT_LAT_MUL   = 4;
  localparam int DEFAULT_LAT_DIV   = 5;

  localparam logic [5:0] RTYPE_VEC = 6'h00;
  localparam logic [5:0] RTYPE_NOP = 6'h3f;
  localparam logic [5:0] MTYPE_LW  = 6'h20;
  localparam logic [5:0] MTYPE_SW  = 6'h28;

  localparam logic [5:0] VAND   = 6'h00;
  localparam logic [5:0] VOR    = 6'h01;
  localparam logic [5:0] VXOR   = 6'h02;
  localparam logic [5:0] VNOT   = 6'h03;
  localparam logic [5:0] VMOV   = 6'h04;
  localparam logic [5:0] VADD   = 6'h08;
  localparam logic [5:0] VSUB   = 6'h09;
  localparam logic [5:0] VSLL   = 6'h10;
  localparam logic [5:0] VSRL   = 6'h11;
  localparam logic [5:0] VSRA   = 6'h12;
  localparam logic [5:0] VRTTH  = 6'h13;
  localparam logic [5:0] VMULEU = 6'h18;
  localparam logic [5:0] VMULOU = 6'h19;
  localparam logic [5:0] VSQEU  = 6'h1a;
  localparam logic [5:0] VSQOU  = 6'h1b;
  localparam logic [5:0] VDIV   = 6'h20;
  localparam logic [5:0] VMOD   = 6'h21;
  localparam logic [5:0] VSQRT  = 6'h22;

  // Stores and anything unrecognised map to NONE so they never reserve a
  // writeback slot; only the R-type vector ops are split by function code.
  function automatic logic [2:0] cardinal_class(input logic [5:0] opcode,
                                                input logic [5:0] funct);
    logic [2:0] cls;
    cls = CLS_NONE;
    if (opcode == MTYPE_LW) begin
      cls = CLS_MEM;
    end else if (opcode == RTYPE_VEC) begin
      case (funct)
        VAND, VOR, VXOR, VNOT, VMOV:   cls = CLS_LOGIC;
        VADD, VSUB:                    cls = CLS_ADD;
        VSLL, VSRL, VSRA, VRTTH:       cls = CLS_SHIFT;
        VMULEU, VMULOU, VSQEU, VSQOU:  cls = CLS_MUL;
        VDIV, VMOD, VSQRT:             cls = CLS_DIV;
        default:                       cls = CLS_NONE;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/wb_slot_ring.sv
// Writeback reservation ring.
// Purpose: DEPTH-deep shift ring; slot i being valid means some instruction
// writes back i cycles from now. Every edge moves all slots one step toward
// index 0, and the head (index 0) is the writeback happening this cycle.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   reserveEn         claim slot reserveIdx (post-shift position) this edge
//   reserveIdx        slot index to claim
//   reserveRd/Class   tags stored with the claimed slot
//   slotVec           current valid bits, used for the collision check
//   headValid/Rd/Class  slot 0 and its tags (registered)
module wb_slot_ring #(
  parameter int DEPTH = 8,
  parameter int RA_W  = 5,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            reserveEn,
  input  logic [IW-1:0]   reserveIdx,
  input  logic [RA_W-1:0] reserveRd,
  input  logic [2:0]      reserveClass,
  output logic [DEPTH-1:0] slotVec,
  output logic            headValid,
  output logic [RA_W-1:0] headRd,
  output logic [2:0]      headClass
);

  logic [DEPTH-1:0] slotValid;
  logic [RA_W-1:0]  rdTag  [DEPTH];
  logic [2:0]       clsTag [DEPTH];

  // Shift everything one slot toward the head each cycle, then let a new
  // reservation land on top. The scoreboard never reserves a slot that the
  // shift is about to fill, so the overwrite can only hit an empty slot.
  // Empty slots carry zero tags so the head outputs read zero when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      slotValid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rdTag[i]  <= '0;
        clsTag[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        slotValid[i] <= slotValid[i+1];
        rdTag[i]     <= rdTag[i+1];
        clsTag[i]    <= clsTag[i+1];
      end
      slotValid[DEPTH-1] <= 1'b0;
      rdTag[DEPTH-1]     <= '0;
      clsTag[DEPTH-1]    <= '0;
      if (reserveEn) begin
        slotValid[reserveIdx] <= 1'b1;
        rdTag[reserveIdx]     <= reserveRd;
        clsTag[reserveIdx]    <= reserveClass;
      end
    end
  end

  // Head of the ring is the writeback stream; these are plain views of
  // registers, so the outputs are registered.
  always_comb begin
    slotVec   = slotValid;
    headValid = slotValid[0];
    headRd    = rdTag[0];
    headClass = clsTag[0];
  end

endmodule

// File: rtl/cardinal_scoreboard.sv
// Cardinal issue and hazard controller.
// Purpose: sits between ID and EX. Tracks a pending-writeback countdown per
// architectural register, detects RAW, WAW and writeback-port collisions for
// the instruction ID presents, and emits the in-order writeback stream from a
// reservation ring.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   issue_valid/class/wr_en    decoded instruction from ID
//   issue_rd/ra/rb (+_used)    destination and source registers
//   stall                      hold IF/ID (combinational)
//   issue_fire                 instruction leaves ID this cycle
//   wb_valid/rd/class          writeback occurring this cycle (registered)
//   busy_vec                   per-register "write still pending" flags
module cardinal_scoreboard
  import cardinal_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int RA_W      = 5,
  parameter int MAX_LAT   = 8,
  parameter int LAT_LOGIC = DEFAULT_LAT_LOGIC,
  parameter int LAT_MEM   = DEFAULT_LAT_MEM,
  parameter int LAT_ADD   = DEFAULT_LAT_ADD,
  parameter int LAT_SHIFT = DEFAULT_LAT_SHIFT,
  parameter int LAT_MUL   = DEFAULT_LAT_MUL,
  parameter int LAT_DIV   = DEFAULT_LAT_DIV,
  parameter int FWD_EN    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [2:0]          issue_class,
  input  logic                issue_wr_en,
  input  logic [RA_W-1:0]     issue_rd,
  input  logic [RA_W-1:0]     issue_ra,
  input  logic                issue_ra_used,
  input  logic [RA_W-1:0]     issue_rb,
  input  logic                issue_rb_used,
  output logic                stall,
  output logic                issue_fire,
  output logic                wb_valid,
  output logic [RA_W-1:0]     wb_rd,
  output logic [2:0]          wb_class,
  output logic [NUM_REGS-1:0] busy_vec
);

  localparam int CW = $clog2(MAX_LAT + 1);
  localparam int IW = $clog2(MAX_LAT);

  logic [CW-1:0]      cnt [NUM_REGS];
  logic [CW-1:0]      lat;
  logic [IW-1:0]      latIdx;
  logic [MAX_LAT-1:0] slotVec;
  logic               trk;
  logic               rawHaz;
  logic               wawHaz;
  logic               structHaz;
  logic               fireTrk;

  // A source blocks issue while its producer is more than one cycle from
  // writing back; on the writeback cycle itself the forward path covers it
  // unless forwarding is disabled.
  function automatic logic srcHazard(input logic used,
                                     input logic [RA_W-1:0] src,
                                     input logic [CW-1:0] c);
    return used && (src != '0) &&
           ((c > CW'(1)) || ((c == CW'(1)) && (FWD_EN == 0)));
  endfunction

  // Latency of the presented class. NONE classes get a harmless value;
  // they are never tracked, so it is never used to reserve anything.
  always_comb begin
    lat = CW'(LAT_LOGIC);
    case (issue_class)
      CLS_MEM:   lat = CW'(LAT_MEM);
      CLS_ADD:   lat = CW'(LAT_ADD);
      CLS_SHIFT: lat = CW'(LAT_SHIFT);
      CLS_MUL:   lat = CW'(LAT_MUL);
      CLS_DIV:   lat = CW'(LAT_DIV);
      default:   lat = CW'(LAT_LOGIC);
    endcase
    latIdx = lat[IW-1:0];
  end

  // Hazard evaluation. WAW stalls while the older write to rd would land
  // at or after the new one; the structural check refuses a latency whose
  // writeback cycle is already claimed in the ring. Reset forces stall low
  // so the pipeline is released immediately.
  always_comb begin
    trk       = issue_wr_en && (issue_rd != '0) && (issue_class <= 3'd5);
    rawHaz    = srcHazard(issue_ra_used, issue_ra, cnt[issue_ra]) ||
                srcHazard(issue_rb_used, issue_rb, cnt[issue_rb]);
    wawHaz    = trk && (cnt[issue_rd] != '0) &&
                ((cnt[issue_rd] - CW'(1)) >= lat);
    structHaz = trk && slotVec[latIdx];
    stall      = issue_valid && !reset && (rawHaz || wawHaz || structHaz);
    issue_fire = issue_valid && !stall;
    fireTrk    = issue_fire && trk;
  end

  // Per-register countdowns. A firing tracked write reloads its register
  // with the full latency, overriding both any older pending value and
  // the decrement from a writeback landing on the same edge. R0 is never
  // tracked and stays zero.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (reset || r == 0) begin
        cnt[r] <= '0;
      end else if (fireTrk && issue_rd == RA_W'(r)) begin
        cnt[r] <= lat;
      end else if (cnt[r] != '0) begin
        cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

  // Busy flags are a direct view of the countdowns.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_vec[r] = (cnt[r] != '0);
    end
  end

  // The ring is reserved at lat-1 because the claim lands on the same
  // edge that shifts the ring; the head then reaches index 0 exactly
  // lat cycles after the fire cycle.
  wb_slot_ring #(
    .DEPTH (MAX_LAT),
    .RA_W  (RA_W),
    .IW    (IW)
  ) ring (
    .clk          (clk),
    .reset        (reset),
    .reserveEn    (fireTrk),
    .reserveIdx   (latIdx - 1'b1),
    .reserveRd    (issue_rd),
    .reserveClass (issue_class),
    .slotVec      (slotVec),
    .headValid    (wb_valid),
    .headRd       (wb_rd),
    .headClass    (wb_class)
  );

endmodule

// File: tb/tb_cardinal_scoreboard.sv
// Self-checking bench for cardinal_scoreboard.
// A scheduling model (per-register landing cycle plus a map from cycle to
// writeback) predicts stall, fire, the writeback stream and busy flags each
// cycle; directed scenarios add hand-computed timing expectations.
module tb_cardinal_scoreboard;
  import cardinal_pkg::*;

  localparam int NUM_REGS = 32;
  localparam int FWD = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       issueValid = 1'b0;
  logic [2:0] issueClass = 3'd6;
  logic       issueWrEn = 1'b0;
  logic [4:0] issueRd = '0, issueRa = '0, issueRb = '0;
  logic       raUsed = 1'b0, rbUsed = 1'b0;
  logic       useDut2 = 1'b0;
  logic       pendingReset = 1'b1, pendingSel = 1'b0;
  logic       v1, v2;
  assign v1 = issueValid && !useDut2;
  assign v2 = issueValid && useDut2;

  logic        stall1, fire1, wbValid1, stall2, fire2, wbValid2;
  logic [4:0]  wbRd1, wbRd2;
  logic [2:0]  wbClass1, wbClass2;
  logic [31:0] busy1, busy2;

  cardinal_scoreboard #(.FWD_EN(1)) dut (
    .clk(clk), .reset(reset), .issue_valid(v1), .issue_class(issueClass),
    .issue_wr_en(issueWrEn), .issue_rd(issueRd), .issue_ra(issueRa),
    .issue_ra_used(raUsed), .issue_rb(issueRb), .issue_rb_used(rbUsed),
    .stall(stall1), .issue_fire(fire1), .wb_valid(wbValid1), .wb_rd(wbRd1),
    .wb_class(wbClass1), .busy_vec(busy1));

  cardinal_scoreboard #(.FWD_EN(0)) dutNoFwd (
    .clk(clk), .reset(reset), .issue_valid(v2), .issue_class(issueClass),
    .issue_wr_en(issueWrEn), .issue_rd(issueRd), .issue_ra(issueRa),
    .issue_ra_used(raUsed), .issue_rb(issueRb), .issue_rb_used(rbUsed),
    .stall(stall2), .issue_fire(fire2), .wb_valid(wbValid2), .wb_rd(wbRd2),
    .wb_class(wbClass2), .busy_vec(busy2));

  int cyc = 0;
  int total = 0;
  int bad = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state: the cycle in which the newest pending write to each
  // register lands, and the set of writebacks keyed by landing cycle.
  int         lastWb [NUM_REGS];
  logic [4:0] schedRd [int];
  logic [2:0] schedCls [int];

  function automatic int latOf(input logic [2:0] c);
    case (c)
      3'd0: return 1;
      3'd1: return 2;
      3'd2, 3'd3: return 3;
      3'd4: return 4;
      3'd5: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic bit srcBlocked(input logic [4:0] s, input logic used);
    if (!used || s == 0) return 1'b0;
    return (lastWb[s] > cyc) || (lastWb[s] == cyc && FWD == 0);
  endfunction

  always @(negedge clk) begin : compare
    int lat;
    bit trk, haz, expStall, expWb;
    logic [31:0] expBusy;
    if (reset) begin
      checkOutput("stallInReset", {63'd0, stall1}, 64'd0);
      for (int r = 0; r < NUM_REGS; r++) lastWb[r] = -1;
      schedRd.delete();
      schedCls.delete();
    end else begin
      lat = latOf(issueClass);
      trk = issueWrEn && issueRd != 0 && issueClass <= 3'd5;
      haz = srcBlocked(issueRa, raUsed) || srcBlocked(issueRb, rbUsed);
      if (trk && ((lastWb[issueRd] >= cyc + lat) || schedRd.exists(cyc + lat)))
        haz = 1'b1;
      expStall = v1 && haz;
      checkOutput("stall", {63'd0, stall1}, {63'd0, expStall});
      checkOutput("fire", {63'd0, fire1}, {63'd0, v1 && !expStall});
      expWb = schedRd.exists(cyc);
      checkOutput("wbValid", {63'd0, wbValid1}, {63'd0, expWb});
      if (expWb) begin
        checkOutput("wbRd", {59'd0, wbRd1}, {59'd0, schedRd[cyc]});
        checkOutput("wbClass", {61'd0, wbClass1}, {61'd0, schedCls[cyc]});
        schedRd.delete(cyc);
        schedCls.delete(cyc);
      end
      for (int r = 0; r < NUM_REGS; r++) expBusy[r] = (lastWb[r] >= cyc);
      checkOutput("busyVec", {32'd0, busy1}, {32'd0, expBusy});
      if (v1 && !expStall && trk) begin
        lastWb[issueRd] = cyc + lat;
        schedRd[cyc + lat] = issueRd;
        schedCls[cyc + lat] = issueClass;
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [2:0] c, input logic w,
                               input logic [4:0] rd, input logic [4:0] ra,
                               input logic raU, input logic [4:0] rb, input logic rbU);
    @(posedge clk);
    #1;
    reset = pendingReset;
    useDut2 = pendingSel;
    issueValid = v; issueClass = c; issueWrEn = w; issueRd = rd;
    issueRa = ra; raUsed = raU; issueRb = rb; rbUsed = rbU;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 3'd6, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic issueUntilFire(input logic [2:0] c, input logic [4:0] rd,
                                input logic [4:0] ra, input logic raU,
                                input logic [4:0] rb, input logic rbU,
                                input int budget, output int fireCyc);
    fireCyc = -1;
    for (int i = 0; i < budget; i++) begin
      applyStimulus(1'b1, c, 1'b1, rd, ra, raU, rb, rbU);
      if ((useDut2 ? fire2 : fire1) === 1'b1) begin
        fireCyc = cyc;
        break;
      end
    end
    checkOutput("issueFiredInBudget", {63'd0, fireCyc >= 0}, 64'd1);
  endtask

  typedef struct packed {
    logic [2:0] c;
    logic [4:0] rd;
    logic [4:0] ra;
    logic       raU;
    logic [4:0] rb;
    logic       rbU;
  } VecT;
  VecT tbl [8];

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t, f;
    tbl[0] = '{3'd2, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0};
    tbl[1] = '{3'd3, 5'd2, 5'd1, 1'b1, 5'd0, 1'b0};
    tbl[2] = '{3'd1, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0};
    tbl[3] = '{3'd4, 5'd3, 5'd2, 1'b1, 5'd1, 1'b1};
    tbl[4] = '{3'd0, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0};
    tbl[5] = '{3'd5, 5'd4, 5'd3, 1'b1, 5'd0, 1'b0};
    tbl[6] = '{3'd1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0};
    tbl[7] = '{3'd0, 5'd6, 5'd5, 1'b1, 5'd4, 1'b1};

    $display("[TB] reset with an ADD R3 held at ID");
    pendingReset = 1'b1;
    applyStimulus(1'b1, CLS_ADD, 1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b1, CLS_ADD, 1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0);
    pendingReset = 1'b0;
    applyStimulus(1'b1, CLS_ADD, 1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("t1StallAfterReset", {63'd0, stall1}, 64'd0);
    checkOutput("t1BusyAfterReset", {32'd0, busy1}, 64'd0);
    checkOutput("t1FirstFire", {63'd0, fire1}, 64'd1);
    idle(3);
    checkOutput("t1WbValidAtT3", {63'd0, wbValid1}, 64'd1);
    checkOutput("t1WbRdAtT3", {59'd0, wbRd1}, 64'd3);
    checkOutput("t1WbClassAtT3", {61'd0, wbClass1}, 64'd2);
    idle(1);
    checkOutput("t1BusyR3AtT4", {63'd0, busy1[3]}, 64'd0);

    $display("[TB] RAW on MUL result, forwarding enabled");
    applyStimulus(1'b1, CLS_MUL, 1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
    t = cyc;
    checkOutput("t2MulFire", {63'd0, fire1}, 64'd1);
    issueUntilFire(CLS_ADD, 5'd6, 5'd5, 1'b1, 5'd1, 1'b1, 10, f);
    checkOutput("t2FwdFireOffset", 64'(f - t), 64'd4);
    idle(6);

    $display("[TB] RAW on MUL result, forwarding disabled");
    pendingSel = 1'b1;
    applyStimulus(1'b1, CLS_MUL, 1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
    t = cyc;
    checkOutput("t2bMulFire", {63'd0, fire2}, 64'd1);
    issueUntilFire(CLS_ADD, 5'd6, 5'd5, 1'b1, 5'd1, 1'b1, 10, f);
    checkOutput("t2bNoFwdFireOffset", 64'(f - t), 64'd5);
    pendingSel = 1'b0;
    idle(6);

    $display("[TB] writeback port collision");
    applyStimulus(1'b1, CLS_DIV, 1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
    t = cyc;
    idle(3);
    issueUntilFire(CLS_LOGIC, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 10, f);
    checkOutput("t3FireOffset", 64'(f - t), 64'd5);
    checkOutput("t3WbR7", {59'd0, wbRd1}, 64'd7);
    idle(1);
    checkOutput("t3WbR8Valid", {63'd0, wbValid1}, 64'd1);
    checkOutput("t3WbR8Rd", {59'd0, wbRd1}, 64'd8);
    idle(2);

    $display("[TB] WAW on R9");
    applyStimulus(1'b1, CLS_DIV, 1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
    t = cyc;
    issueUntilFire(CLS_LOGIC, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 10, f);
    checkOutput("t4FireOffset", 64'(f - t), 64'd5);
    checkOutput("t4FirstWbRd", {59'd0, wbRd1}, 64'd9);
    checkOutput("t4FirstWbClass", {61'd0, wbClass1}, 64'd5);
    idle(1);
    checkOutput("t4SecondWbRd", {59'd0, wbRd1}, 64'd9);
    checkOutput("t4SecondWbClass", {61'd0, wbClass1}, 64'd0);
    idle(1);

    $display("[TB] untracked writes and R0 sources");
    applyStimulus(1'b1, CLS_ADD, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    checkOutput("t5R0Stall", {63'd0, stall1}, 64'd0);
    applyStimulus(1'b1, CLS_NONE, 1'b1, 5'd10, 5'd0, 1'b1, 5'd0, 1'b0);
    checkOutput("t5NoneStall", {63'd0, stall1}, 64'd0);
    applyStimulus(1'b1, 3'd7, 1'b1, 5'd11, 5'd0, 1'b0, 5'd0, 1'b1);
    checkOutput("t5Class7Stall", {63'd0, stall1}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      checkOutput("t5NoWb", {63'd0, wbValid1}, 64'd0);
    end
    checkOutput("t5NoBusy", {32'd0, busy1}, 64'd0);

    $display("[TB] reset with writes in flight");
    applyStimulus(1'b1, CLS_DIV, 1'b1, 5'd12, 5'd0, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b1, CLS_MUL, 1'b1, 5'd13, 5'd0, 1'b0, 5'd0, 1'b0);
    pendingReset = 1'b1;
    applyStimulus(1'b1, CLS_ADD, 1'b1, 5'd14, 5'd0, 1'b0, 5'd0, 1'b0);
    pendingReset = 1'b0;
    applyStimulus(1'b1, CLS_ADD, 1'b1, 5'd12, 5'd13, 1'b1, 5'd14, 1'b1);
    checkOutput("t6StallAfterReset", {63'd0, stall1}, 64'd0);
    checkOutput("t6FireAfterReset", {63'd0, fire1}, 64'd1);
    checkOutput("t6BusyAfterReset", {32'd0, busy1}, 64'd0);
    for (int i = 1; i <= 5; i++) begin
      idle(1);
      checkOutput("t6WbStream", {63'd0, wbValid1}, {63'd0, i == 3});
    end

    $display("[TB] back-to-back dependent sequence");
    foreach (tbl[k]) begin
      issueUntilFire(tbl[k].c, tbl[k].rd, tbl[k].ra, tbl[k].raU, tbl[k].rb, tbl[k].rbU, 12, f);
    end
    idle(8);
    checkOutput("t7Drained", {32'd0, busy1}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
